// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO controller with up to 32 bidirectional pins.
// Supports atomic SET/CLR/TGL output writes and 2-flop input synchronisers.
// Each pin has a rising- or falling-edge interrupt; irq_o = |(IP & IE).
// Optional feature macro: GPIO_DEBOUNCE_EN adds a per-pin stability filter
// (DEBOUNCE_CYCLES) between the synchroniser and the edge detector.

// Per-pin input path: synchroniser, optional debounce filter, edge detect.
module wb_gpio_irq_pin
`ifdef GPIO_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pad,
  input  logic i_edge_sel,   // 0 = rising, 1 = falling
  output logic o_in_s,
  output logic o_hit
);
  logic r_sync1, r_sync2, r_in_d;
  logic w_in_s;

  // Two-flop synchroniser for the asynchronous pad value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Accept a new level only after it has differed from the filtered value for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end
  assign w_in_s = r_filt;
`else
  assign w_in_s = r_sync2;
`endif

  // Delayed copy of in_s; edges are only real transitions of in_s, so
  // reprogramming EDGE never fabricates one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_in_d <= 1'b0;
    else          r_in_d <= w_in_s;
  end

  assign o_in_s = w_in_s;
  assign o_hit  = i_edge_sel ? (~w_in_s & r_in_d) : (w_in_s & ~r_in_d);
endmodule

module wb_gpio_irq #(
  parameter int          N_GPIO    = 16,
  parameter logic [31:0] DIR_RESET = '1
`ifdef GPIO_DEBOUNCE_EN
  ,parameter int         DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [4:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              irq_o,
  inout  wire  [N_GPIO-1:0] gpio_io
);
  localparam logic [2:0] R_DATA = 3'd0, R_DIR = 3'd1, R_SET = 3'd2, R_CLR = 3'd3,
                         R_TGL  = 3'd4, R_IE  = 3'd5, R_IP  = 3'd6, R_EDGE = 3'd7;

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [N_GPIO-1:0] r_out, r_dir, r_ie, r_ip, r_edge;
  logic [N_GPIO-1:0] w_pad, w_in_s, w_hit, w_w1c;
  logic [N_GPIO-1:0] w_d, w_m;
  logic [31:0]       w_wmask, w_wd, w_rdata;
  logic [2:0]        w_reg;
  logic              w_acc, w_wr;
  logic              w_unused;

  assign w_reg   = wb_adr_i[4:2];
  assign w_acc   = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr    = w_acc & wb_we_i;
  assign w_wmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wd    = wb_dat_i & w_wmask;
  assign w_m     = w_wmask[N_GPIO-1:0];
  assign w_d     = w_wd[N_GPIO-1:0];
  assign w_w1c   = (w_wr && w_reg == R_IP) ? w_d : '0;
  assign w_unused = ^{wb_adr_i[1:0], w_wd, w_wmask};

  // Pads: drive OUT where DIR marks an output, otherwise release.
  for (genvar g = 0; g < N_GPIO; g++) begin : g_pad
    assign gpio_io[g] = r_dir[g] ? 1'bz : r_out[g];
  end
  assign w_pad = gpio_io;

  wb_gpio_irq_pin
`ifdef GPIO_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_pin [N_GPIO-1:0] (
      .i_clk      (wb_clk_i),
      .i_rst_n    (wb_rst_ni),
      .i_pad      (w_pad),
      .i_edge_sel (r_edge),
      .o_in_s     (w_in_s),
      .o_hit      (w_hit)
    );

  // Read mux; SET/CLR/TGL are write-only and read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      R_DATA:  w_rdata = 32'(w_in_s);
      R_DIR:   w_rdata = 32'(r_dir);
      R_IE:    w_rdata = 32'(r_ie);
      R_IP:    w_rdata = 32'(r_ip);
      R_EDGE:  w_rdata = 32'(r_edge);
      default: w_rdata = '0;
    endcase
  end

  // Single-cycle ack per strobe, never back-to-back; read data rides with ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wb_we_i) ? w_rdata : '0;
    end
  end

  // Control registers, written on the acking edge with per-byte masking.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_out  <= '0;
      r_dir  <= DIR_RESET[N_GPIO-1:0];
      r_ie   <= '0;
      r_edge <= '0;
    end else if (w_wr) begin
      case (w_reg)
        R_DATA:  r_out  <= (r_out  & ~w_m) | w_d;
        R_DIR:   r_dir  <= (r_dir  & ~w_m) | w_d;
        R_SET:   r_out  <= r_out | w_d;
        R_CLR:   r_out  <= r_out & ~w_d;
        R_TGL:   r_out  <= r_out ^ w_d;
        R_IE:    r_ie   <= (r_ie   & ~w_m) | w_d;
        R_EDGE:  r_edge <= (r_edge & ~w_m) | w_d;
        default: ;
      endcase
    end
  end

  // Pending bits: a new edge wins over a simultaneous write-1-to-clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_ip <= '0;
    else            r_ip <= (r_ip & ~w_w1c) | w_hit;
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = |(r_ip & r_ie);
endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: scoreboard bench for wb_gpio_irq (N_GPIO=16).
// Build with GPIO_DEBOUNCE_EN to also exercise the debounce filter.
module tb_wb_gpio_irq;
  localparam int N = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT_EXTRA = 4;
`else
  localparam int LAT_EXTRA = 0;
`endif
  localparam logic [4:0] A_DATA = 5'd0,  A_DIR = 5'd4,  A_SET = 5'd8,  A_CLR = 5'd12,
                         A_TGL  = 5'd16, A_IE  = 5'd20, A_IP  = 5'd24, A_EDGE = 5'd28;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [4:0]  adr = '0;
  logic [31:0] dat_i = '0, dat_o;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [3:0]  sel = '0;
  logic        ack, irq;
  wire  [N-1:0] gpio;
  logic [N-1:0] tb_drv = '0, tb_oe = '1;
  int          errs = 0, checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_tbpad
    assign gpio[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
  end

  wb_gpio_irq #(.N_GPIO(N)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_ack_o(ack), .irq_o(irq), .gpio_io(gpio));

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // One Wishbone access; ack must arrive exactly one cycle after strobe.
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    int n = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    r = dat_o;
    checks++;
    if (!ack || n != 1) begin
      errs++; $display("FAIL ack_latency adr=%h got_cycles=%0d ack=%b want_cycles=1", a, n, ack);
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r;
    bus(1'b1, a, d, s, r);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] r);
    bus(1'b0, a, '0, 4'hF, r);
  endtask

  task automatic test_reset;
    logic [4:0]  a[6] = '{A_DIR, A_IE, A_IP, A_EDGE, A_SET, A_DATA};
    logic [31:0] v, e;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 1'b0) begin
      errs++; $display("FAIL reset_outputs got ack=%b dat=%h irq=%b want 0/0/0", ack, dat_o, irq);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    exp_q.push_back(32'h0000FFFF);
    repeat (5) exp_q.push_back(32'h0);
    foreach (a[i]) begin
      rd(a[i], v); e = exp_q.pop_front(); checks++;
      if (v !== e) begin errs++; $display("FAIL reset_read adr=%h got=%h want=%h", a[i], v, e); end
    end
    // Pads are released: an external pattern reads straight back.
    tb_drv = 16'h5A5A;
    repeat (4) @(posedge clk);
    exp_q.push_back(32'h5A5A);
    rd(A_DATA, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL reset_highz got=%h want=%h", v, e); end
    tb_drv = '0;
    repeat (4) @(posedge clk);
    wr(A_IP, 32'hFFFF);
    exp_q.push_back(32'h0);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL reset_ip_w1c got=%h want=%h", v, e); end
  endtask

  task automatic test_atomic;
    logic [31:0] v, e;
    wr(A_DIR, 32'h0);
    tb_oe = '0;
    wr(A_DATA, 32'h00F0); wr(A_SET, 32'h0003); wr(A_CLR, 32'h0010); wr(A_TGL, 32'h0101);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (gpio !== 16'h01E2) begin errs++; $display("FAIL atomic_pads got=%h want=01e2", gpio); end
    exp_q.push_back(32'h01E2); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(A_DATA, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL atomic_data got=%h want=%h", v, e); end
    rd(A_SET, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL atomic_set_rd got=%h want=%h", v, e); end
    rd(A_TGL, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL atomic_tgl_rd got=%h want=%h", v, e); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] v, e;
    wr(A_DATA, 32'hAAAA, 4'hF); wr(A_DATA, 32'h5555, 4'b0001);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (gpio !== 16'hAA55) begin errs++; $display("FAIL lanes_pads got=%h want=aa55", gpio); end
    exp_q.push_back(32'hAA55);
    rd(A_DATA, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL lanes_lo got=%h want=%h", v, e); end
    wr(A_DATA, 32'h0000_1200, 4'b0010);
    wr(A_DIR, 32'hFFFF_0000, 4'b1100);   // only bits above N_GPIO selected
    repeat (3) @(posedge clk);
    exp_q.push_back(32'h1255); exp_q.push_back(32'h0);
    rd(A_DATA, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL lanes_hi got=%h want=%h", v, e); end
    rd(A_DIR, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL lanes_dir_upper got=%h want=%h", v, e); end
  endtask

  task automatic test_irq;
    logic [31:0] v, e;
    wr(A_DIR, 32'hFFFF);
    tb_drv = '0; tb_oe = '1;
    repeat (4 + LAT_EXTRA) @(posedge clk);
    wr(A_IP, 32'hFFFF); wr(A_IE, 32'h1); wr(A_EDGE, 32'h0);
    #1 checks++;
    if (irq !== 1'b0) begin errs++; $display("FAIL irq_idle got=%b want=0", irq); end
    tb_drv[0] = 1'b1;
    repeat (4 + LAT_EXTRA) @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errs++; $display("FAIL irq_assert got=%b want=1", irq); end
    exp_q.push_back(32'h1);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL irq_ip_set got=%h want=%h", v, e); end
    wr(A_IP, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errs++; $display("FAIL irq_clear got=%b want=0", irq); end
    tb_drv[0] = 1'b0;
    tb_drv[1] = 1'b1;   // pin1 edge pends but IE[1]=0 keeps irq low
    repeat (4 + LAT_EXTRA) @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin errs++; $display("FAIL irq_gated got=%b want=0", irq); end
    exp_q.push_back(32'h2);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL irq_fall_ignored got=%h want=%h", v, e); end
    wr(A_IP, 32'h2);
  endtask

  task automatic test_edge_sel;
    logic [31:0] v, e;
    // Reprogramming EDGE with steady pins must not pend anything.
    wr(A_EDGE, 32'hFFFF); wr(A_EDGE, 32'h0); wr(A_EDGE, 32'h2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h2); exp_q.push_back(32'h2);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL edge_no_spurious got=%h want=%h", v, e); end
    tb_drv[1] = 1'b0;
    repeat (4 + LAT_EXTRA) @(posedge clk);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL edge_falling got=%h want=%h", v, e); end
    rd(A_EDGE, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL edge_readback got=%h want=%h", v, e); end
    wr(A_IP, 32'h2); wr(A_EDGE, 32'h0);
  endtask

  task automatic test_race;
    logic [31:0] v, e;
    tb_drv[3] = 1'b1;
    repeat (4 + LAT_EXTRA) @(posedge clk);
    tb_drv[3] = 1'b0;
    repeat (4 + LAT_EXTRA) @(posedge clk);
    exp_q.push_back(32'h8);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL race_setup got=%h want=%h", v, e); end
    // The new pin3 edge lands on IP at the same edge the W1C is acked.
    @(posedge clk); #1 tb_drv[3] = 1'b1;
    repeat (2 + LAT_EXTRA) @(posedge clk);
    #1 cyc = 1; stb = 1; we = 1; adr = A_IP; dat_i = 32'h8; sel = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin errs++; $display("FAIL race_ack got=%b want=1", ack); end
    cyc = 0; stb = 0; we = 0;
    exp_q.push_back(32'h8);
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL race_set_wins got=%h want=%h", v, e); end
    tb_drv[3] = 1'b0;
    repeat (4 + LAT_EXTRA) @(posedge clk);
    wr(A_IP, 32'hFFFF);
  endtask

  task automatic test_back_to_back;
    logic       want[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] v;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = A_DIR; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) v = dat_o;
      checks++;
      if (ack !== want[i]) begin errs++; $display("FAIL b2b_ack cyc=%0d got=%b want=%b", i, ack, want[i]); end
    end
    cyc = 0; stb = 0;
    checks++;
    if (v !== 32'hFFFF) begin errs++; $display("FAIL b2b_data got=%h want=0000ffff", v); end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] v, e;
    @(posedge clk); #1 tb_drv[2] = 1'b1;
    repeat (3) @(posedge clk); #1 tb_drv[2] = 1'b0;
    repeat (10) @(posedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(A_DATA, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL db_short_data got=%h want=%h", v, e); end
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL db_short_ip got=%h want=%h", v, e); end
    @(posedge clk); #1 tb_drv[2] = 1'b1;
    repeat (6) @(posedge clk);
    exp_q.push_back(32'h4); exp_q.push_back(32'h4);
    rd(A_DATA, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL db_long_data got=%h want=%h", v, e); end
    tb_drv[2] = 1'b0;
    rd(A_IP, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL db_long_ip got=%h want=%h", v, e); end
    repeat (10) @(posedge clk);
    wr(A_IP, 32'hFFFF);
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] v, e;
    tb_drv = '0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = A_DIR; dat_i = 32'h0; sel = 4'hF;
    #2 rst_n = 0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0) begin
      errs++; $display("FAIL rstmid_ack got ack=%b dat=%h want 0/0", ack, dat_o);
    end
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1 rst_n = 1;
    exp_q.push_back(32'hFFFF); exp_q.push_back(32'h0);
    rd(A_DIR, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL rstmid_dir got=%h want=%h", v, e); end
    rd(A_IE, v); e = exp_q.pop_front(); checks++;
    if (v !== e) begin errs++; $display("FAIL rstmid_ie got=%h want=%h", v, e); end
  endtask

  initial begin
    test_reset();
    test_atomic();
    test_byte_lanes();
    test_irq();
    test_edge_sel();
    test_race();
    test_back_to_back();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
